// File: rtl/cnn_fmap_feeder.sv
// Window feeder for the CI accumulator: serially loads one kernel's weights, then
// slides a KY x KX window over a row-major CI-channel pixel stream (stride 1, no padding).
module cnn_fmap_feeder #(
  parameter int CI     = 4,
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         soft_reset_i,
  input  logic                         start_i,
  input  logic                         w_valid_i,
  input  logic [W_BW-1:0]              w_data_i,
  output logic                         w_ready_o,
  input  logic                         px_valid_i,
  input  logic [CI*I_F_BW-1:0]         px_data_i,
  output logic                         px_ready_o,
  output logic                         ot_valid_o,
  output logic [CI*KX*KY*W_BW-1:0]     ot_weight_o,
  output logic [CI*KX*KY*I_F_BW-1:0]   ot_fmap_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int NE  = CI * KY * KX;
  localparam int PB  = CI * I_F_BW;
  localparam int WCW = (NE > 1) ? $clog2(NE) : 1;
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [WCW-1:0] W_LAST  = WCW'(NE - 1);
  localparam logic [CW-1:0]  C_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0]  C_FIRST = CW'(KX - 1);
  localparam logic [RW-1:0]  R_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0]  R_FIRST = RW'(KY - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_W = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  logic [1:0]                 state_reg;
  logic [WCW-1:0]             w_cnt_reg;
  logic [CW-1:0]              col_reg;
  logic [RW-1:0]              row_reg;
  logic                       ot_valid_reg;
  logic                       done_reg;
  logic [NE*I_F_BW-1:0]       ot_fmap_reg;
  logic [NE*W_BW-1:0]         ot_weight_reg;

  // lb[j][c] holds the pixel at column c of row (r - (KY-1) + j), r being the current row.
  logic [PB-1:0] lb [KY-1][IMG_W];
  logic [PB-1:0] win [KY][KX];
  logic [PB-1:0] win_next [KY][KX];
  logic [PB-1:0] col_in [KY];
  logic [NE*I_F_BW-1:0] win_flat;

  logic w_acc, px_acc, win_emit, last_px;

  assign w_acc    = w_valid_i && (state_reg == S_LOAD_W);
  assign px_acc   = px_valid_i && (state_reg == S_RUN);
  assign win_emit = px_acc && (row_reg >= R_FIRST) && (col_reg >= C_FIRST);
  assign last_px  = px_acc && (row_reg == R_LAST) && (col_reg == C_LAST);

  genvar gi, gj, gk;
  generate
    for (gi = 0; gi < KY; gi++) begin : g_col_in
      if (gi < KY - 1) begin : g_lb
        assign col_in[gi] = lb[gi][col_reg];
      end else begin : g_px
        assign col_in[gi] = px_data_i;
      end
      for (gj = 0; gj < KX; gj++) begin : g_shift
        if (gj < KX - 1) begin : g_mid
          assign win_next[gi][gj] = win[gi][gj+1];
        end else begin : g_new
          assign win_next[gi][gj] = col_in[gi];
        end
      end
    end
    for (gk = 0; gk < CI; gk++) begin : g_pack_ci
      for (gi = 0; gi < KY; gi++) begin : g_pack_ky
        for (gj = 0; gj < KX; gj++) begin : g_pack_kx
          assign win_flat[((gk*KY+gi)*KX+gj)*I_F_BW +: I_F_BW] =
            win_next[gi][gj][gk*I_F_BW +: I_F_BW];
        end
      end
    end
  endgenerate

  // Storage only; its contents are meaningless until a row has been refilled.
  always_ff @(posedge clk) begin
    if (px_acc) begin
      for (int j = 0; j < KY - 1; j++) begin
        lb[j][col_reg] <= col_in[j+1];
      end
      win <= win_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      w_cnt_reg     <= '0;
      col_reg       <= '0;
      row_reg       <= '0;
      ot_valid_reg  <= 1'b0;
      done_reg      <= 1'b0;
      ot_fmap_reg   <= '0;
      ot_weight_reg <= '0;
    end else if (soft_reset_i) begin
      state_reg     <= S_IDLE;
      w_cnt_reg     <= '0;
      col_reg       <= '0;
      row_reg       <= '0;
      ot_valid_reg  <= 1'b0;
      done_reg      <= 1'b0;
      ot_fmap_reg   <= '0;
      ot_weight_reg <= '0;
    end else begin
      ot_valid_reg <= win_emit;
      done_reg     <= last_px;
      if (win_emit) ot_fmap_reg <= win_flat;
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            state_reg <= S_LOAD_W;
            w_cnt_reg <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
          end
        end
        S_LOAD_W: begin
          if (w_acc) begin
            ot_weight_reg[w_cnt_reg*W_BW +: W_BW] <= w_data_i;
            if (w_cnt_reg == W_LAST) begin
              w_cnt_reg <= '0;
              state_reg <= S_RUN;
            end else begin
              w_cnt_reg <= w_cnt_reg + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (px_acc) begin
            if (col_reg == C_LAST) begin
              col_reg <= '0;
              if (row_reg == R_LAST) begin
                row_reg   <= '0;
                state_reg <= S_IDLE;
              end else begin
                row_reg <= row_reg + 1'b1;
              end
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign w_ready_o   = (state_reg == S_LOAD_W);
  assign px_ready_o  = (state_reg == S_RUN);
  assign busy_o      = (state_reg != S_IDLE);
  assign done_o      = done_reg;
  assign ot_valid_o  = ot_valid_reg;
  assign ot_fmap_o   = ot_fmap_reg;
  assign ot_weight_o = ot_weight_reg;

endmodule

// File: tb/tb_cnn_fmap_feeder.sv
// Scoreboard bench for cnn_fmap_feeder: the driver queues expected windows as pixels
// are accepted; an independent monitor pops and compares on every window pulse.
module tb_cnn_fmap_feeder;
  localparam int CI = 2, KX = 3, KY = 3, IB = 8, WB = 8, IW = 4, IH = 4;
  localparam int NE = CI * KX * KY;
  localparam int FBW = NE * IB;

  logic clk, reset_n, soft_reset_i, start_i, w_valid_i, w_ready_o;
  logic px_valid_i, px_ready_o, ot_valid_o, busy_o, done_o;
  logic [WB-1:0] w_data_i;
  logic [CI*IB-1:0] px_data_i;
  logic [NE*WB-1:0] ot_weight_o;
  logic [FBW-1:0] ot_fmap_o;

  cnn_fmap_feeder #(.CI(CI), .KX(KX), .KY(KY), .I_F_BW(IB), .W_BW(WB),
                    .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .reset_n(reset_n), .soft_reset_i(soft_reset_i), .start_i(start_i),
    .w_valid_i(w_valid_i), .w_data_i(w_data_i), .w_ready_o(w_ready_o),
    .px_valid_i(px_valid_i), .px_data_i(px_data_i), .px_ready_o(px_ready_o),
    .ot_valid_o(ot_valid_o), .ot_weight_o(ot_weight_o), .ot_fmap_o(ot_fmap_o),
    .busy_o(busy_o), .done_o(done_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [FBW-1:0] fmap; int cyc; bit done; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  int win_seen = 0;
  bit dot_chk = 0;
  logic [FBW-1:0] first_win;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [IB-1:0] pix_ch(input int md, input int r, input int c, input int ci);
    if (md == 2) return 8'd1;
    return IB'((md == 1 ? 50 : 0) + ci * 100 + IW * r + c);
  endfunction

  function automatic logic [CI*IB-1:0] pix(input int md, input int r, input int c);
    logic [CI*IB-1:0] p;
    for (int ci = 0; ci < CI; ci++) p[ci*IB +: IB] = pix_ch(md, r, c, ci);
    return p;
  endfunction

  function automatic logic [FBW-1:0] exp_fmap(input int md, input int r, input int c);
    logic [FBW-1:0] v;
    for (int ci = 0; ci < CI; ci++)
      for (int ky = 0; ky < KY; ky++)
        for (int kx = 0; kx < KX; kx++)
          v[((ci*KY+ky)*KX+kx)*IB +: IB] = pix_ch(md, r - KY + 1 + ky, c - KX + 1 + kx, ci);
    return v;
  endfunction

  function automatic logic [WB-1:0] wval(input int set, input int k);
    if (set == 0) return WB'(k);
    if (set == 1) return WB'(255 - k);
    return 8'd1;
  endfunction

  function automatic logic [NE*WB-1:0] exp_weights(input int set);
    logic [NE*WB-1:0] v;
    for (int k = 0; k < NE; k++) v[k*WB +: WB] = wval(set, k);
    return v;
  endfunction

  function automatic int dot_now();
    int s = 0;
    for (int n = 0; n < NE; n++) s += int'(ot_weight_o[n*WB +: WB]) * int'(ot_fmap_o[n*IB +: IB]);
    return s;
  endfunction

  // Monitor: every window pulse (or done pulse) must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ot_valid_o || done_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got valid=%0b done=%0b expected none (cycle %0d)",
                   ot_valid_o, done_o, cyc);
        end else begin
          e = q.pop_front();
          chk("win_valid", ot_valid_o, 1);
          chk("win_fmap", ot_fmap_o, e.fmap);
          chk("win_cycle", cyc, e.cyc);
          chk("win_done", done_o, e.done);
          if (dot_chk) chk("acc_dot", dot_now(), NE);
          if (win_seen == 0) first_win = ot_fmap_o;
          win_seen++;
          $display("window cycle=%0d done=%0b fmap=%h", cyc, done_o, ot_fmap_o);
        end
      end
    end
  end

  task automatic start_job();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_w_ready", w_ready_o, 1);
    chk("start_busy", busy_o, 1);
  endtask

  task automatic load_weights(input int set, input bit poke_start);
    int k = 0, lim = 0, wr = 0;
    while (k < NE && lim < 200) begin
      @(negedge clk);
      lim++;
      start_i   = poke_start && (k == 5);
      w_valid_i = 1'b1;
      w_data_i  = wval(set, k);
      if (w_ready_o) begin
        wr++;
        k++;
      end
    end
    @(negedge clk);
    w_valid_i = 1'b0;
    start_i   = 1'b0;
    chk("load_accepts", k, NE);
    chk("w_ready_cycles", wr, NE);
    chk("w_ready_low_after", w_ready_o, 0);
    chk("px_ready_after_load", px_ready_o, 1);
    chk("weights", ot_weight_o, exp_weights(set));
    $display("weights loaded set=%0d cycle=%0d", set, cyc);
  endtask

  task automatic stream(input int md, input bit bubbles, input bit poke_start,
                        input int stop_after, input bit b2b);
    int idx = 0, lim = 0, r, c;
    exp_t e;
    bit v;
    while (idx < stop_after && lim < 500) begin
      @(negedge clk);
      lim++;
      r = idx / IW;
      c = idx % IW;
      start_i    = poke_start && (idx == 5);
      v          = bubbles ? ($urandom_range(0, 1) == 1) : 1'b1;
      px_valid_i = v;
      px_data_i  = pix(md, r, c);
      if (v && px_ready_o) begin
        if (r >= KY - 1 && c >= KX - 1) begin
          e.fmap = exp_fmap(md, r, c);
          e.cyc  = cyc + 1;
          e.done = (idx == IW * IH - 1);
          q.push_back(e);
        end
        idx++;
      end
    end
    @(negedge clk);
    px_valid_i = 1'b0;
    start_i    = 1'b0;
    chk("stream_accepts", idx, stop_after);
    if (stop_after == IW * IH) begin
      chk("done_pulse", done_o, 1);
      chk("done_busy_low", busy_o, 0);
      chk("done_px_ready_low", px_ready_o, 0);
      if (b2b) start_i = 1'b1;
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_w_ready"}, w_ready_o, 0);
    chk({tag, "_px_ready"}, px_ready_o, 0);
    chk({tag, "_valid"}, ot_valid_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_fmap"}, ot_fmap_o, 0);
    chk({tag, "_weight"}, ot_weight_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IB-1:0] hand0 [9];
    hand0 = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    reset_n = 1'b0; soft_reset_i = 1'b0; start_i = 1'b0; w_valid_i = 1'b0;
    w_data_i = '0; px_valid_i = 1'b0; px_data_i = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("in_reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_zero("after_reset");

    // Job 1: contiguous stream, stray start_i during load and run.
    win_seen = 0;
    start_job();
    load_weights(0, 1'b1);
    stream(0, 1'b0, 1'b1, IW * IH, 1'b0);
    repeat (3) @(negedge clk);
    chk("job1_windows", win_seen, 4);
    for (int n = 0; n < 9; n++) begin
      chk("first_win_ch0", first_win[n*IB +: IB], hand0[n]);
      chk("first_win_ch1", first_win[(9+n)*IB +: IB], hand0[n] + 8'd100);
    end

    // Job 2: random bubbles on the pixel stream.
    win_seen = 0;
    start_job();
    load_weights(0, 1'b0);
    stream(0, 1'b1, 1'b0, IW * IH, 1'b0);
    repeat (3) @(negedge clk);
    chk("job2_windows", win_seen, 4);

    // Job 3: soft reset after 7 pixels, then a clean job chained back-to-back.
    start_job();
    load_weights(0, 1'b0);
    stream(0, 1'b0, 1'b0, 7, 1'b0);
    soft_reset_i = 1'b1;
    @(negedge clk);
    soft_reset_i = 1'b0;
    check_idle_zero("soft_reset");
    repeat (4) @(negedge clk);
    win_seen = 0;
    start_job();
    load_weights(0, 1'b0);
    stream(0, 1'b0, 1'b0, IW * IH, 1'b1);
    @(negedge clk);
    start_i = 1'b0;
    chk("b2b_busy", busy_o, 1);
    chk("b2b_w_ready", w_ready_o, 1);
    chk("b2b_weight_hold", ot_weight_o, exp_weights(0));
    load_weights(1, 1'b0);
    stream(1, 1'b0, 1'b0, IW * IH, 1'b0);
    repeat (3) @(negedge clk);
    chk("b2b_windows", win_seen, 8);

    // Job 4: all-ones weights and pixels; every window dot product is CI*KX*KY.
    dot_chk = 1'b1;
    start_job();
    load_weights(2, 1'b0);
    stream(2, 1'b0, 1'b0, IW * IH, 1'b0);
    repeat (3) @(negedge clk);
    dot_chk = 1'b0;

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
